// File: rtl/pio_in_edge_irq_pkg.sv
// Shared definitions for the input PIO: register map, edge selection codes
// and the edge-detect helper used by the PIO top.
package pio_in_edge_irq_pkg;

    typedef logic [31:0] word_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // One-cycle edge pulses between the current and previous debounced vectors.
    function automatic word_t edge_vec(input int edge_type, input word_t cur, input word_t prev);
        word_t res;
        case (edge_type)
            EDGE_FALLING: res = ~cur & prev;
            EDGE_ANY:     res = cur ^ prev;
            default:      res = cur & ~prev;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus bundle (read latency 1) for the input PIO.
interface pio_in_edge_irq_if;
    import pio_in_edge_irq_pkg::*;

    logic [1:0] address;
    logic       chipselect;
    logic       write;
    word_t      writedata;
    word_t      readdata;

    modport master (
        output address, chipselect, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write, writedata,
        output readdata
    );

endinterface

// File: rtl/pio_in_edge_irq_sync_debounce.sv
// Single input bit: synchroniser chain followed by an optional stable-count
// debouncer whose output only follows the input after DEBOUNCE_CYCLES agreeing samples.
module pio_sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic stable_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign stable_o = s;
        end else begin : g_debounce
            localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          stable_q, stable_d;

            // Any agreement with the held value restarts the count, so short glitches vanish.
            always_comb begin
                cnt_d    = '0;
                stable_d = stable_q;
                if (s != stable_q) begin
                    if (cnt_q == CNT_LAST) begin
                        stable_d = s;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign stable_o = stable_q;
        end
    endgenerate

endmodule

// File: rtl/pio_in_edge_irq.sv
// Parametrised Avalon-MM input PIO: per-bit sync/debounce, edge capture,
// interrupt mask and a registered level IRQ.
module pio_in_edge_irq
    import pio_in_edge_irq_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = EDGE_RISING
) (
    input  logic              clk,
    input  logic              reset_n,
    pio_in_edge_irq_if.slave  avs,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    word_t            readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            pio_sync_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_sync_debounce (
                .clk      (clk),
                .reset_n  (reset_n),
                .d_i      (in_port[gi]),
                .stable_o (stable[gi])
            );
        end
    endgenerate

    assign wr_en = avs.chipselect & avs.write;

    always_comb begin
        edge_hit = WIDTH'(edge_vec(EDGE_TYPE, word_t'(stable), word_t'(prev_q)));
        clr      = (wr_en && avs.address == ADDR_EDGE) ? avs.writedata[WIDTH-1:0] : '0;
        // OR-ing the new edge after the clear lets a simultaneous set win.
        edgecap_d = (edgecap_q & ~clr) | edge_hit;
        irqmask_d = (wr_en && avs.address == ADDR_MASK) ? avs.writedata[WIDTH-1:0] : irqmask_q;
        irq_d     = |(edgecap_q & irqmask_q);

        // No read strobe: the bus address is sampled every cycle.
        readdata_d = '0;
        case (avs.address)
            ADDR_DATA: readdata_d = word_t'(stable);
            ADDR_MASK: readdata_d = word_t'(irqmask_q);
            ADDR_EDGE: readdata_d = word_t'(edgecap_q);
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            edgecap_q  <= '0;
            irqmask_q  <= '0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            prev_q     <= stable;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign avs.readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: four parameter sets driven in parallel against a
// sample-window reference model, with directed scenarios plus random traffic.
module tb_pio_in_edge_irq;
    import pio_in_edge_irq_pkg::*;

    localparam int          NI    = 4;
    localparam int          W     = 10;
    localparam logic [31:0] WMASK = 32'h3FF;

    function automatic int s_of(input int i);
        case (i)
            0: return 2;
            1: return 2;
            2: return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int d_of(input int i);
        case (i)
            1: return 4;
            3: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int e_of(input int i);
        case (i)
            2: return EDGE_ANY;
            3: return EDGE_FALLING;
            default: return EDGE_RISING;
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   address = '0;
    logic         chipselect = 1'b0;
    logic         write = 1'b0;
    logic [31:0]  writedata = '0;
    logic [W-1:0] in_port = '0;

    logic [31:0]  rd_w  [NI];
    logic         irq_w [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            pio_in_edge_irq_if bus_if ();
            assign bus_if.address    = address;
            assign bus_if.chipselect = chipselect;
            assign bus_if.write      = write;
            assign bus_if.writedata  = writedata;
            assign rd_w[gi]          = bus_if.readdata;

            pio_in_edge_irq #(
                .WIDTH           (W),
                .SYNC_STAGES     (s_of(gi)),
                .DEBOUNCE_CYCLES (d_of(gi)),
                .EDGE_TYPE       (e_of(gi))
            ) u_dut (
                .clk     (clk),
                .reset_n (reset_n),
                .avs     (bus_if),
                .in_port (in_port),
                .irq     (irq_w[gi])
            );
        end
    endgenerate

    // Reference model: samp[j] is in_port as sampled j edges ago.
    logic [31:0] m_samp   [NI][16];
    logic [31:0] m_stable [NI];
    logic [31:0] m_prev   [NI];
    logic [31:0] m_ec     [NI];
    logic [31:0] m_mask   [NI];
    logic [31:0] m_rd     [NI];
    logic        m_irq    [NI];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < 16; j++) m_samp[i][j] = '0;
            m_stable[i] = '0;
            m_prev[i]   = '0;
            m_ec[i]     = '0;
            m_mask[i]   = '0;
            m_rd[i]     = '0;
            m_irq[i]    = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [31:0] clr, hit, and_v, or_v;
        logic        wr;
        int          s, d;
        if (!reset_n) begin
            model_reset();
            return;
        end
        wr = chipselect && write;
        for (int i = 0; i < NI; i++) begin
            s = s_of(i);
            d = d_of(i);
            clr = (wr && address == 2'd3) ? (writedata & WMASK) : 32'h0;
            case (e_of(i))
                EDGE_RISING:  hit = m_stable[i] & ~m_prev[i];
                EDGE_FALLING: hit = ~m_stable[i] & m_prev[i];
                default:      hit = m_stable[i] ^ m_prev[i];
            endcase
            case (address)
                2'd0: m_rd[i] = m_stable[i];
                2'd2: m_rd[i] = m_mask[i];
                2'd3: m_rd[i] = m_ec[i];
                default: m_rd[i] = 32'h0;
            endcase
            m_irq[i] = |(m_ec[i] & m_mask[i]);
            m_ec[i]  = (m_ec[i] & ~clr) | hit;
            if (wr && address == 2'd2) m_mask[i] = writedata & WMASK;
            m_prev[i] = m_stable[i];
            for (int j = 15; j > 0; j--) m_samp[i][j] = m_samp[i][j-1];
            m_samp[i][0] = 32'(in_port);
            if (d == 0) begin
                m_stable[i] = m_samp[i][s-1];
            end else begin
                // A bit moves only once its last D synchronised samples all agree.
                and_v = 32'hFFFF_FFFF;
                or_v  = 32'h0;
                for (int j = s; j < s + d; j++) begin
                    and_v &= m_samp[i][j];
                    or_v  |= m_samp[i][j];
                end
                m_stable[i] = and_v | (m_stable[i] & or_v);
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("u%0d_readdata", i), rd_w[i], m_rd[i]);
            check_eq($sformatf("u%0d_irq", i), 32'(irq_w[i]), 32'(m_irq[i]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        $display("write addr=%0d data=%h in_port=%h", a, d, in_port);
        cycle();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Reset state
        repeat (3) cycle();
        reset_n = 1'b1;

        // Data read and power-up rising edges
        in_port = 10'h2A5;
        address = 2'd0;
        repeat (10) cycle();
        check_eq("plan_data_2a5", rd_w[0], 32'h0000_02A5);
        address = 2'd3;
        repeat (2) cycle();
        check_eq("plan_edge_2a5", rd_w[0], 32'h0000_02A5);
        check_eq("plan_irq_unmasked", 32'(irq_w[0]), 32'h0);

        // Masked interrupt on bit0 and its clear
        bus_write(2'd3, 32'h3FF);
        bus_write(2'd2, 32'h001);
        in_port = 10'h2A4;
        repeat (12) cycle();
        bus_write(2'd3, 32'h3FF);
        in_port = 10'h2A5;
        repeat (4) cycle();
        check_eq("plan_irq_set", 32'(irq_w[0]), 32'h1);
        bus_write(2'd3, 32'h001);
        cycle();
        check_eq("plan_irq_cleared", 32'(irq_w[0]), 32'h0);

        // Debounce: short pulse rejected, long hold accepted
        address = 2'd0;
        in_port = in_port | 10'h008;
        repeat (3) cycle();
        in_port = in_port & ~10'h008;
        repeat (10) cycle();
        check_eq("plan_glitch_dropped", 32'(rd_w[1][3]), 32'h0);
        in_port = in_port | 10'h008;
        repeat (10) cycle();
        check_eq("plan_hold_accepted", 32'(rd_w[1][3]), 32'h1);

        // Any-edge capture on bit5, both directions
        bus_write(2'd3, 32'h3FF);
        in_port = in_port ^ 10'h020;
        repeat (20) cycle();
        check_eq("plan_any_first", 32'(rd_w[2][5]), 32'h1);
        bus_write(2'd3, 32'h020);
        in_port = in_port ^ 10'h020;
        repeat (20) cycle();
        check_eq("plan_any_second", 32'(rd_w[2][5]), 32'h1);

        // Clear and new edge on bit2 at the same clock edge
        in_port = in_port & ~10'h004;
        repeat (8) cycle();
        bus_write(2'd3, 32'h3FF);
        in_port = in_port | 10'h004;
        repeat (2) cycle();
        bus_write(2'd3, 32'h004);
        cycle();
        check_eq("plan_set_beats_clear", 32'(rd_w[0][2]), 32'h1);
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'hFFFF_FFFF);
        address = 2'd1;
        cycle();
        check_eq("plan_rsvd_zero", rd_w[0], 32'h0);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) in_port = in_port ^ (10'(1) << $urandom_range(0, W-1));
            else if (r == 2) in_port = in_port ^ (10'(1) << $urandom_range(0, 1));
            chipselect = ($urandom_range(0, 3) != 0);
            write      = ($urandom_range(0, 3) == 0);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            if (chipselect && write)
                $display("write addr=%0d data=%h in_port=%h", address, writedata, in_port);
            cycle();
        end
        chipselect = 1'b0;
        write      = 1'b0;

        // Asynchronous reset in the middle of a debounce with irq high
        in_port = '0;
        repeat (12) cycle();
        bus_write(2'd3, 32'h3FF);
        bus_write(2'd2, 32'h3FF);
        address = 2'd2;
        in_port = 10'h200;
        repeat (4) cycle();
        check_eq("plan_irq_before_reset", 32'(irq_w[0]), 32'h1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("u%0d_async_rd", i), rd_w[i], 32'h0);
            check_eq($sformatf("u%0d_async_irq", i), 32'(irq_w[i]), 32'h0);
        end
        repeat (2) cycle();
        reset_n = 1'b1;
        address = 2'd0;
        repeat (15) cycle();
        address = 2'd3;
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pio_in_edge_irq.md
# pio_in_edge_irq

Parametrised Avalon-MM input PIO for the Nios II lab platform, replacing the fixed 10-bit switch port. It adds several features to the plain data read:
- input synchronisation
- optional per-bit debounce
- per-bit edge capture
- an interrupt mask and a level interrupt to the CPU

The block sits on the system interconnect as a slave with read latency 1 and drives one IRQ line.

## Interface
- WIDTH, 10: number of input bits, 1..32.
- SYNC_STAGES, 2: synchroniser flops per bit, 2..4.
- DEBOUNCE_CYCLES, 0: stable-cycle count before the debounced value follows the input; 0 bypasses debounce.
- EDGE_TYPE, 0: edge that sets the capture bit; 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write  in  1  write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous external inputs (switches, keys).
- irq  out  1  registered level interrupt.

## Operation
- Register map, each register zero-extended to 32 bits on read:
  - 0: data, the debounced value; writes ignored.
  - 1: reserved; reads 0, writes ignored.
  - 2: irqmask, read/write.
  - 3: edgecapture; reads are non-destructive; a write clears each bit whose writedata bit is 1.
- Synchroniser: SYNC_STAGES flop chain per bit, output s.
- Debounce, per bit, when DEBOUNCE_CYCLES > 0. The counter width is clog2(DEBOUNCE_CYCLES+1).
  - s == stable: cnt <= 0.
  - s != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s, cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is discarded.
- Debounce bypass (DEBOUNCE_CYCLES == 0): stable = s.
- Edge detect: prev <= stable every cycle.
  - rising: stable & ~prev
  - falling: ~stable & prev
  - any: stable ^ prev
- Edge capture: edgecapture <= (edgecapture & ~clr) | edge.
  - A set on the same cycle as a clear of the same bit wins; the bit stays 1.
- irq <= |(edgecapture & irqmask).
- readdata <= mux(address) every cycle. No read strobe is used; the returned value reflects the address presented one cycle earlier.
- Writes take effect only when chipselect & write. Write data bits [31:WIDTH] are ignored.

## Timing
- Reset values, all 0: readdata, irq, irqmask, edgecapture, synchroniser flops, stable, prev, debounce counters.
- An input held at 1 through reset release produces one rising edge once it propagates. This is required behaviour, and software clears edgecapture at init.
- Input-to-register latency, for an in_port change settled before clk edge k, with D = DEBOUNCE_CYCLES:
  - stable changes after edge k+SYNC_STAGES-1+D.
  - edgecapture is set at edge k+SYNC_STAGES+D.
  - irq is asserted at edge k+SYNC_STAGES+D+1, if the bit is masked in.
- Read latency 1 cycle.
- Register updates from a write at edge n:
  - irqmask/edgecapture update at edge n.
  - irq reflects the update at edge n+1.
  - readdata reflects the update on a read addressed at edge n+1 or later.
- A reset assertion mid-debounce aborts the count; no partial state survives.

## Structure
- Shared package, included by this block and the platform top:
  - register address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_MASK=2, ADDR_EDGE=3
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY constants
- One sub-module, pio_sync_debounce: a single bit holding the synchroniser, debounce counter and stable flop, parametrised by SYNC_STAGES/DEBOUNCE_CYCLES. It is instantiated WIDTH times in a generate loop.
- The top holds edge detect, registers, read mux and irq.

## Test plan
- Reset, then in_port=10'h2A5 with D=0 → read address 0 returns 32'h000002A5. Per Timing, the 1-bits of 10'h2A5 each record a rising edge, so edgecapture holds 0x2A5 with irq=0 (mask 0).
- irqmask=0x001; in_port bit0 0→1 → edgecapture=0x001 at edge k+2 and irq=1 at edge k+3. Write 0x001 to address 3 → edgecapture=0 and irq=0 one cycle later.
- D=4: bit3 pulses high for 3 cycles → data, edgecapture unchanged. Bit3 held high for 10 cycles → data bit3=1 at edge k+SYNC_STAGES-1+4.
- EDGE_TYPE=2: bit5 toggles 0→1→0, with the two changes 20 cycles apart → edgecapture bit5 set after the first change. Clear it, then the second change sets it again.
- Clear of bit2 at the same edge a new bit2 edge arrives → edgecapture bit2 stays 1. Writes to addresses 0 and 1 → no register change; address 1 reads 0.
- Assert reset_n mid-debounce with irq=1 → irq, readdata, irqmask and edgecapture are 0 immediately. After release, data follows in_port with full latency.
